// File: rtl/turf_udp_timeserver_pkg.sv
// rtl/turf_udp_timeserver_pkg.sv - shared types, constants and helpers for the UDP time server
package turf_udp_timeserver_pkg;

    localparam logic [7:0] OP_ALIGNED   = 8'h00;
    localparam logic [7:0] OP_IMMED     = 8'h01;
    localparam logic [7:0] OP_IMMED_EXT = 8'h02;

    typedef enum logic [1:0] {
        MODE_ALIGNED   = 2'd0,
        MODE_IMMED     = 2'd1,
        MODE_IMMED_EXT = 2'd2
    } mode_t;

    localparam logic [15:0] LEN_ALIGNED   = 16'd4;
    localparam logic [15:0] LEN_IMMED     = 16'd8;
    localparam logic [15:0] LEN_IMMED_EXT = 16'd12;

    typedef enum logic {
        ING_HDR,
        ING_DATA
    } ing_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_HDR,
        R_D0,
        R_D1
    } rep_state_t;

    typedef struct packed {
        logic [31:0] ip;
        logic [15:0] port;
        mode_t       mode;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    // Unknown opcodes fall back to the PPS-aligned reply.
    function automatic mode_t decode_op(input logic [7:0] op);
        case (op)
            OP_IMMED:     return MODE_IMMED;
            OP_IMMED_EXT: return MODE_IMMED_EXT;
            default:      return MODE_ALIGNED;
        endcase
    endfunction

    function automatic logic [15:0] reply_len(input mode_t m);
        case (m)
            MODE_IMMED:     return LEN_IMMED;
            MODE_IMMED_EXT: return LEN_IMMED_EXT;
            default:        return LEN_ALIGNED;
        endcase
    endfunction

    // Network byte order for a 32-bit word placed little-endian on the stream.
    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/turf_udp_timeserver_fifo.sv
// rtl/turf_udp_timeserver_fifo.sv - first-word fall-through request queue
module turf_udp_timeserver_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [WIDTH-1:0]         din,
    input  logic                     wr_en,
    output logic                     full,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    input  logic                     rd_en,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == FULL_CNT);
    assign valid = (r_count != '0);
    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign w_wr  = wr_en && !full;
    assign w_rd  = rd_en && valid;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/turf_udp_timeserver_mc.sv
// rtl/turf_udp_timeserver_mc.sv - multi-mode UDP time server: ingest, two queues, counters, reply
module turf_udp_timeserver_mc
    import turf_udp_timeserver_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SUBSEC_BITS = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [63:0]                   s_udphdr_tdata,
    input  logic                          s_udphdr_tvalid,
    output logic                          s_udphdr_tready,
    input  logic [63:0]                   s_udpdata_tdata,
    input  logic [7:0]                    s_udpdata_tkeep,
    input  logic                          s_udpdata_tlast,
    input  logic                          s_udpdata_tvalid,
    output logic                          s_udpdata_tready,
    output logic [63:0]                   m_udphdr_tdata,
    output logic                          m_udphdr_tvalid,
    input  logic                          m_udphdr_tready,
    output logic [63:0]                   m_udpdata_tdata,
    output logic [7:0]                    m_udpdata_tkeep,
    output logic                          m_udpdata_tlast,
    output logic                          m_udpdata_tvalid,
    input  logic                          m_udpdata_tready,
    input  logic                          pps_i,
    input  logic [31:0]                   cur_sec_i,
    output logic [15:0]                   drop_count_o,
    output logic [$clog2(FIFO_DEPTH):0]   aligned_level_o,
    output logic [$clog2(FIFO_DEPTH):0]   immed_level_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    ing_state_t             r_ing_state, w_ing_next;
    rep_state_t             r_rep_state, w_rep_next;
    logic [31:0]            r_req_ip;
    logic [15:0]            r_req_port;
    logic [7:0]             r_op;
    logic                   r_first;
    logic [SUBSEC_BITS-1:0] r_subsec;
    logic [SUBSEC_BITS-1:0] r_period;
    logic [LW-1:0]          r_release;
    logic [15:0]            r_drop;
    logic                   r_sel_al;
    mode_t                  r_mode;
    logic [31:0]            r_sec, r_ss, r_per;

    logic                   w_hdr_hs, w_dat_hs, w_push, w_push_al, w_push_im, w_drop;
    logic [7:0]             w_op;
    mode_t                  w_mode;
    req_entry_t             w_entry, w_al_head, w_im_head, w_head;
    logic                   w_al_full, w_im_full, w_al_valid, w_im_valid;
    logic                   w_pop_al, w_pop_im, w_al_avail, w_rep_hdr_hs;
    logic [LW-1:0]          w_al_count, w_im_count;
    logic                   w_unused;

    assign w_unused = &{1'b0, s_udphdr_tdata[15:0], s_udpdata_tdata[63:8], s_udpdata_tkeep};

    assign w_hdr_hs  = s_udphdr_tvalid && s_udphdr_tready;
    assign w_dat_hs  = s_udpdata_tvalid && s_udpdata_tready;
    assign w_op      = r_first ? s_udpdata_tdata[7:0] : r_op;
    assign w_mode    = decode_op(w_op);
    assign w_push    = w_dat_hs && s_udpdata_tlast;
    assign w_push_al = w_push && (w_mode == MODE_ALIGNED);
    assign w_push_im = w_push && (w_mode != MODE_ALIGNED);
    assign w_drop    = (w_push_al && w_al_full) || (w_push_im && w_im_full);

    always_comb begin
        w_entry      = '0;
        w_entry.ip   = r_req_ip;
        w_entry.port = r_req_port;
        w_entry.mode = w_mode;
    end

    turf_udp_timeserver_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_aligned_q (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .din     (w_entry),
        .wr_en   (w_push_al),
        .full    (w_al_full),
        .dout    (w_al_head),
        .valid   (w_al_valid),
        .rd_en   (w_pop_al),
        .count   (w_al_count)
    );

    turf_udp_timeserver_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_immed_q (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .din     (w_entry),
        .wr_en   (w_push_im),
        .full    (w_im_full),
        .dout    (w_im_head),
        .valid   (w_im_valid),
        .rd_en   (w_pop_im),
        .count   (w_im_count)
    );

    assign aligned_level_o = w_al_count;
    assign immed_level_o   = w_im_count;
    assign drop_count_o    = r_drop;

    // Ingest state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_ing_state <= ING_HDR;
        else          r_ing_state <= w_ing_next;
    end

    // Ingest next state and readies; readies are held low while reset is asserted.
    always_comb begin
        w_ing_next       = r_ing_state;
        s_udphdr_tready  = 1'b0;
        s_udpdata_tready = 1'b0;
        case (r_ing_state)
            ING_HDR: begin
                s_udphdr_tready = aresetn;
                if (w_hdr_hs) w_ing_next = ING_DATA;
            end
            ING_DATA: begin
                s_udpdata_tready = aresetn;
                if (w_push) w_ing_next = ING_HDR;
            end
            default: w_ing_next = ING_HDR;
        endcase
    end

    // Request fields: source address on the header, opcode from the first payload beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_req_ip   <= '0;
            r_req_port <= '0;
            r_op       <= '0;
            r_first    <= 1'b0;
        end else begin
            if (w_hdr_hs) begin
                r_req_ip   <= s_udphdr_tdata[63:32];
                r_req_port <= s_udphdr_tdata[31:16];
                r_first    <= 1'b1;
            end else if (w_dat_hs) begin
                if (r_first) r_op <= s_udpdata_tdata[7:0];
                r_first <= 1'b0;
            end
        end
    end

    // Sub-second count, last PPS period, release budget and drop counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_subsec  <= '0;
            r_period  <= '0;
            r_release <= '0;
            r_drop    <= '0;
        end else begin
            if (pps_i) begin
                r_subsec <= '0;
                r_period <= (r_subsec == '1) ? r_subsec : r_subsec + 1'b1;
            end else if (r_subsec != '1) begin
                r_subsec <= r_subsec + 1'b1;
            end
            // Pre-edge count excludes a same-cycle push, so that entry waits a full PPS.
            if (pps_i)
                r_release <= w_al_count - LW'(w_pop_al);
            else if (w_pop_al && r_release != '0)
                r_release <= r_release - 1'b1;
            if (w_drop && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;
        end
    end

    assign w_al_avail   = (r_release != '0) && w_al_valid;
    assign w_head       = r_sel_al ? w_al_head : w_im_head;
    assign w_rep_hdr_hs = (r_rep_state == R_HDR) && m_udphdr_tready;
    assign w_pop_al     = w_rep_hdr_hs && r_sel_al;
    assign w_pop_im     = w_rep_hdr_hs && !r_sel_al;

    // Reply state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rep_state <= R_IDLE;
        else          r_rep_state <= w_rep_next;
    end

    // Reply next state and stream outputs; valids depend only on state.
    always_comb begin
        w_rep_next       = r_rep_state;
        m_udphdr_tvalid  = 1'b0;
        m_udphdr_tdata   = '0;
        m_udpdata_tvalid = 1'b0;
        m_udpdata_tdata  = '0;
        m_udpdata_tkeep  = '0;
        m_udpdata_tlast  = 1'b0;
        case (r_rep_state)
            R_IDLE: begin
                if (w_al_avail || w_im_valid) w_rep_next = R_HDR;
            end
            R_HDR: begin
                m_udphdr_tvalid = 1'b1;
                m_udphdr_tdata  = {w_head.ip, w_head.port, reply_len(w_head.mode)};
                if (m_udphdr_tready) w_rep_next = R_D0;
            end
            R_D0: begin
                m_udpdata_tvalid = 1'b1;
                m_udpdata_tdata  = {bswap32(r_ss), bswap32(r_sec)};
                m_udpdata_tkeep  = (r_mode == MODE_ALIGNED) ? 8'h0F : 8'hFF;
                m_udpdata_tlast  = (r_mode != MODE_IMMED_EXT);
                if (m_udpdata_tready)
                    w_rep_next = (r_mode == MODE_IMMED_EXT) ? R_D1 : R_IDLE;
            end
            R_D1: begin
                m_udpdata_tvalid = 1'b1;
                m_udpdata_tdata  = {32'h0, bswap32(r_per)};
                m_udpdata_tkeep  = 8'h0F;
                m_udpdata_tlast  = 1'b1;
                if (m_udpdata_tready) w_rep_next = R_IDLE;
            end
            default: w_rep_next = R_IDLE;
        endcase
    end

    // Queue selection while idle; time snapshot taken at the header handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sel_al <= 1'b0;
            r_mode   <= MODE_ALIGNED;
            r_sec    <= '0;
            r_ss     <= '0;
            r_per    <= '0;
        end else begin
            if (r_rep_state == R_IDLE) r_sel_al <= w_al_avail;
            if (w_rep_hdr_hs) begin
                r_mode <= w_head.mode;
                r_sec  <= cur_sec_i;
                r_ss   <= 32'(r_subsec);
                r_per  <= 32'(r_period);
            end
        end
    end

endmodule
